fp_mul_rr_scheduler: RTL and testbench
======================================

Name: fp_mul_rr_scheduler

Overview:
Round-robin scheduler that shares one pipelined FP32 approximate multiplier among NREQ requesters. Each requester uses a valid/ready handshake. The block issues at most one operand pair per cycle, tracks requester tags through a shift pipeline matched to the multiplier latency, and routes each result back to its originator. It sits between requesting compute lanes and the single fixed-latency FP32 multiplier instance, which has no stall input.

Parameters:
NREQ, 4, number of requesters (2..8)
MUL_LAT, 4, cycles from the mul_a/mul_b presentation cycle to the matching mul_y cycle (fixed, no stall)
CNT_W, 16, width of the issue counter

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous active-high reset
req_valid  input  NREQ  per-requester operand valid
req_ready  output  NREQ  per-requester grant; one-hot or zero
req_a  input  NREQ*32  operand A, requester i at bits [32i+31:32i]
req_b  input  NREQ*32  operand B, same packing
mul_a  output  32  registered operand A to the multiplier
mul_b  output  32  registered operand B to the multiplier
mul_y  input  32  multiplier result
rsp_valid  output  NREQ  one-hot one-cycle result strobe per requester
rsp_y  output  32  result data, valid when any rsp_valid bit is set
busy  output  1  high while any issue is in flight
issue_cnt  output  CNT_W  total accepted requests, wraps modulo 2^CNT_W

Behaviour:
- Reset values: req_ready, mul_a, mul_b, rsp_valid, rsp_y, issue_cnt all 0. busy 0. Pointer 0. All tag-pipeline valid bits 0.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, wrapping modulo NREQ.
  - The first set bit wins, and req_ready of the winner is asserted.
  - req_ready may depend on req_valid; requesters must not wait for ready before raising valid.
  - req_ready is all zero during rst.
- Handshake on cycle c (req_valid[i] and req_ready[i]):
  - Next edge: mul_a and mul_b load req_a[i] and req_b[i].
  - Tag stage 0 loads {valid=1, id=i}.
  - ptr loads (i+1) mod NREQ.
  - issue_cnt increments.
- No handshake in a cycle: mul_a and mul_b hold, ptr holds, tag stage 0 loads valid=0.
- Tag pipeline: MUL_LAT+1 stages of {valid, id[clog2(NREQ)-1:0]}, shifting every cycle. The last stage aligns with the cycle in which mul_y carries the issued result.
- Response path: when the last stage is valid, the next edge sets rsp_valid[id]=1 and rsp_y=mul_y. Otherwise rsp_valid=0 and rsp_y holds its previous value.
- Latency: handshake cycle c gives rsp_valid during cycle c+MUL_LAT+2, which is 6 with defaults.
- Throughput: one issue per cycle. Responses cannot be refused; requesters must sink rsp_valid unconditionally.
- Ordering: results return in issue order. Back-to-back grants to the same requester are allowed when it is the only one valid.
- busy = OR of all tag-stage valid bits.
- Simultaneous events: a new handshake and a response in the same cycle are independent. Responses for requester i and a new grant to i may coincide.
- Reset mid-operation clears all tag valids, so in-flight results are discarded. No rsp_valid is asserted for any pre-reset issue, even though mul_y may still carry stale data.
- issue_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Pointer wraps from NREQ-1 to 0.

Optional Feature:
Macro FP_MUL_SCHED_ZERO_BYPASS_EN. The multiplier always inserts a hidden 1 and mishandles zero operands; this feature corrects that.
- Defined:
  - At handshake, compute zf = (req_a[i][30:23]==0) OR (req_b[i][30:23]==0) and zs = req_a[i][31] XOR req_b[i][31].
  - Carry zf and zs in each tag stage.
  - At response, if zf is set, rsp_y = {zs, 31'b0} instead of mul_y. Timing and latency are unchanged.
- Undefined: no extra tag bits; rsp_y always equals mul_y.

Test Plan:
The bench uses a stub multiplier with y = a XOR b, delayed exactly MUL_LAT cycles, NREQ=4, MUL_LAT=4.
1. Single request: only req 2 valid with a=0x40400000, b=0x40000000 -> req_ready=4'b0100 in that cycle, rsp_valid=4'b0100 six cycles later, rsp_y=0x00400000, issue_cnt=1.
2. Contention: all 4 valid continuously for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; rsp_valid one-hot in the same order starting 6 cycles after the first grant; issue_cnt=8.
3. Sparse fairness: reqs 1 and 3 valid, ptr=2 -> grant 3, then 1, then 3; never two consecutive grants to the same requester while the other waits.
4. Reset mid-flight: 3 issues, then rst high for 1 cycle at issue+2 -> no rsp_valid for those issues, busy=0 after reset, issue_cnt=0, ptr=0.
5. Counter wrap: CNT_W=4, 17 accepted requests -> issue_cnt=1.
6. With FP_MUL_SCHED_ZERO_BYPASS_EN: a=0x80000000, b=0x3F800000 -> rsp_y=0x80000000 at latency 6. Without the macro: rsp_y=0xBF800000 (stub XOR).

Source files
------------

// File: rtl/fp_mul_rr_scheduler.sv
// fp_mul_rr_scheduler
//   Shares one fixed-latency, non-stallable FP32 multiplier among NREQ
//   requesters. It uses round-robin arbitration with a valid/ready handshake
//   and issues at most one operand pair per cycle. A tag shift pipeline
//   follows each issue through the multiplier so that every result is routed
//   back to the requester that issued it.
//
//   Optional build macro FP_MUL_SCHED_ZERO_BYPASS_EN: the multiplier always
//   inserts a hidden 1, so it mishandles zero/denormal operands. With this
//   macro defined, the scheduler carries a zero flag and a sign bit in each
//   tag stage. When the zero flag is set, the response is replaced by a
//   signed zero.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   req_valid  [NREQ]      per-requester operand valid
//   req_ready  [NREQ]      per-requester grant, one-hot or zero
//   req_a      [NREQ*32]   operand A, requester i at [32i+31:32i]
//   req_b      [NREQ*32]   operand B, same packing
//   mul_a      [32]        registered operand A to the multiplier
//   mul_b      [32]        registered operand B to the multiplier
//   mul_y      [32]        multiplier result, MUL_LAT cycles after mul_a/mul_b
//   rsp_valid  [NREQ]      one-hot, one-cycle result strobe
//   rsp_y      [32]        result data
//   busy                   any issue still in flight
//   issue_cnt  [CNT_W]     accepted requests, wraps silently
module fp_mul_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_y,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_y,
  output logic                 busy,
  output logic [CNT_W-1:0]     issue_cnt
);

  localparam int unsigned N   = NREQ;
  localparam int          IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt_id;
  logic             found;
  logic             fire;
  int unsigned      idx;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [IDW-1:0]   ptr_next;

  logic [MUL_LAT:0] tag_v;
  logic [IDW-1:0]   tag_id [MUL_LAT+1];
`ifdef FP_MUL_SCHED_ZERO_BYPASS_EN
  logic [MUL_LAT:0] tag_zf;
  logic [MUL_LAT:0] tag_zs;
  logic             zf;
  logic             zs;
`endif

  // Rotating priority search: the first valid requester at or after ptr wins.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = IDW'(idx);
      end
    end
  end

  assign fire      = found && !rst;
  assign req_ready = fire ? (NREQ'(1) << gnt_id) : '0;
  assign sel_a     = req_a[32*int'(gnt_id) +: 32];
  assign sel_b     = req_b[32*int'(gnt_id) +: 32];
  assign ptr_next  = (32'(gnt_id) == N - 1) ? '0 : gnt_id + IDW'(1);
  assign busy      = |tag_v;

`ifdef FP_MUL_SCHED_ZERO_BYPASS_EN
  assign zf = (sel_a[30:23] == 8'd0) || (sel_b[30:23] == 8'd0);
  assign zs = sel_a[31] ^ sel_b[31];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      issue_cnt <= '0;
      rsp_valid <= '0;
      rsp_y     <= '0;
      tag_v     <= '0;
      for (int unsigned k = 0; k <= MUL_LAT; k++) tag_id[k] <= '0;
`ifdef FP_MUL_SCHED_ZERO_BYPASS_EN
      tag_zf    <= '0;
      tag_zs    <= '0;
`endif
    end else begin
      if (fire) begin
        mul_a     <= sel_a;
        mul_b     <= sel_b;
        ptr       <= ptr_next;
        issue_cnt <= issue_cnt + CNT_W'(1);
      end

      // Stage 0 corresponds to the cycle in which mul_a/mul_b are presented.
      // Stage MUL_LAT therefore lines up with the matching mul_y.
      tag_v     <= {tag_v[MUL_LAT-1:0], fire};
      tag_id[0] <= gnt_id;
      for (int unsigned k = 1; k <= MUL_LAT; k++) tag_id[k] <= tag_id[k-1];
`ifdef FP_MUL_SCHED_ZERO_BYPASS_EN
      tag_zf    <= {tag_zf[MUL_LAT-1:0], zf};
      tag_zs    <= {tag_zs[MUL_LAT-1:0], zs};
`endif

      if (tag_v[MUL_LAT]) begin
        rsp_valid <= NREQ'(1) << tag_id[MUL_LAT];
`ifdef FP_MUL_SCHED_ZERO_BYPASS_EN
        rsp_y     <= tag_zf[MUL_LAT] ? {tag_zs[MUL_LAT], 31'b0} : mul_y;
`else
        rsp_y     <= mul_y;
`endif
      end else begin
        rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_rr_scheduler.sv
// Directed testbench for fp_mul_rr_scheduler (NREQ=4, MUL_LAT=4).
// The stub multiplier computes y = a ^ b, delayed by exactly MUL_LAT cycles.
// A second instance with CNT_W=4 shares the same inputs; it is used to
// check that issue_cnt wraps.
module tb_fp_mul_rr_scheduler;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]   req_ready, req_ready_w;
  logic [31:0]       mul_a, mul_b, mul_a_w, mul_b_w, mul_y;
  logic [NREQ-1:0]   rsp_valid, rsp_valid_w;
  logic [31:0]       rsp_y, rsp_y_w;
  logic              busy, busy_w;
  logic [15:0]       issue_cnt;
  logic [3:0]        issue_cnt_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_mul_rr_scheduler #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
    .rsp_valid(rsp_valid), .rsp_y(rsp_y), .busy(busy), .issue_cnt(issue_cnt)
  );

  fp_mul_rr_scheduler #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_w),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a_w), .mul_b(mul_b_w), .mul_y(mul_y),
    .rsp_valid(rsp_valid_w), .rsp_y(rsp_y_w), .busy(busy_w), .issue_cnt(issue_cnt_w)
  );

  // Stub multiplier: result for the pair presented in cycle p appears in cycle p+MUL_LAT.
  logic [31:0] pipe [MUL_LAT];
  always_ff @(posedge clk) begin
    pipe[0] <= mul_a ^ mul_b;
    for (int k = 1; k < MUL_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mul_y = pipe[MUL_LAT-1];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle_start();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] a_of(input int i);
    return 32'h1111_1111 * (i + 1);
  endfunction

  function automatic logic [31:0] b_of(input int i);
    return 32'h0F00_0000 | i;
  endfunction

  initial begin
    logic [3:0]  exp_rv;
    logic [31:0] exp_y;
    int          id;

    // Reset values; req_ready must stay low during rst even with all requesters valid.
    rst = 1'b1;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    cycle_start();
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    cycle_start();
    check("rst_mul_a", mul_a, 32'h0);
    check("rst_mul_b", mul_b, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_y", rsp_y, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cnt", 32'(issue_cnt), 32'h0);
    rst = 1'b0;
    req_valid = '0;

    // 1. Single request from requester 2.
    cycle_start();
    set_op(2, 32'h4040_0000, 32'h4000_0000);
    req_valid = 4'b0100;
    #1;
    check("t1_ready", 32'(req_ready), 32'h4);
    for (int t = 1; t <= 6; t++) begin
      cycle_start();
      req_valid = '0;
      #1;
      if (t == 1) begin
        check("t1_mul_a", mul_a, 32'h4040_0000);
        check("t1_busy", 32'(busy), 32'h1);
      end
      check("t1_rsp_valid", 32'(rsp_valid), (t == 6) ? 32'h4 : 32'h0);
    end
    check("t1_rsp_y", rsp_y, 32'h0040_0000);
    check("t1_cnt", 32'(issue_cnt), 32'h1);

    // 2. Full contention for 8 cycles, starting from reset.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, a_of(i), b_of(i));
    for (int t = 0; t < 16; t++) begin
      cycle_start();
      req_valid = (t < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (t < 8) check("t2_ready", 32'(req_ready), 32'(4'b0001 << (t % 4)));
      exp_rv = (t >= 6 && t < 14) ? (4'b0001 << ((t - 6) % 4)) : 4'b0000;
      check("t2_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (t >= 6 && t < 14) begin
        id = (t - 6) % 4;
        exp_y = a_of(id) ^ b_of(id);
        check("t2_rsp_y", rsp_y, exp_y);
      end
    end
    check("t2_cnt", 32'(issue_cnt), 32'd8);

    // 3. Sparse fairness: a grant to requester 1 moves ptr to 2, then 1 and 3 alternate.
    cycle_start();
    req_valid = 4'b0010;
    #1;
    check("t3_ready_pre", 32'(req_ready), 32'h2);
    cycle_start();
    req_valid = 4'b1010;
    #1;
    check("t3_ready_a", 32'(req_ready), 32'h8);
    cycle_start();
    #1;
    check("t3_ready_b", 32'(req_ready), 32'h2);
    cycle_start();
    #1;
    check("t3_ready_c", 32'(req_ready), 32'h8);
    cycle_start();
    req_valid = '0;

    // 4. Reset while three issues are in flight.
    do_reset();
    for (int t = 0; t < 3; t++) begin
      cycle_start();
      req_valid = 4'b0001;
      #1;
      check("t4_ready", 32'(req_ready), 32'h1);
    end
    cycle_start();
    req_valid = '0;
    cycle_start();
    rst = 1'b1;
    for (int t = 5; t < 15; t++) begin
      cycle_start();
      rst = 1'b0;
      #1;
      if (t == 5) begin
        check("t4_busy", 32'(busy), 32'h0);
        check("t4_cnt", 32'(issue_cnt), 32'h0);
      end
      check("t4_no_rsp", 32'(rsp_valid), 32'h0);
    end
    cycle_start();
    req_valid = 4'b1111;
    #1;
    check("t4_ptr0", 32'(req_ready), 32'h1);
    cycle_start();
    req_valid = '0;

    // 5. Counter wrap: 17 issues give 1 on the 4-bit instance.
    do_reset();
    for (int t = 0; t < 17; t++) begin
      cycle_start();
      req_valid = 4'b1111;
    end
    cycle_start();
    req_valid = '0;
    #1;
    check("t5_cnt16", 32'(issue_cnt), 32'd17);
    check("t5_cnt4_wrap", 32'(issue_cnt_w), 32'd1);

    // 6. Zero operand: a signed-zero bypass when the macro is defined, raw stub result otherwise.
    do_reset();
    cycle_start();
    set_op(0, 32'h8000_0000, 32'h3F80_0000);
    req_valid = 4'b0001;
    #1;
    check("t6_ready", 32'(req_ready), 32'h1);
    for (int t = 1; t <= 6; t++) begin
      cycle_start();
      req_valid = '0;
      #1;
      check("t6_rsp_valid", 32'(rsp_valid), (t == 6) ? 32'h1 : 32'h0);
    end
`ifdef FP_MUL_SCHED_ZERO_BYPASS_EN
    check("t6_rsp_y", rsp_y, 32'h8000_0000);
`else
    check("t6_rsp_y", rsp_y, 32'hBF80_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
